// File: rtl/cp0_unit_if.sv
// Exception/CP0 access bus between the M-stage pipeline (master) and cp0_unit (slave).
interface cp0_unit_if;
  logic        en;
  logic [4:0]  CP0Add;
  logic [31:0] CP0In;
  logic [31:0] CP0Out;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] EPCOut;
  logic        Req;

  modport master (
    output en, CP0Add, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    input  CP0Out, EPCOut, Req
  );

  modport slave (
    input  en, CP0Add, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    output CP0Out, EPCOut, Req
  );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0 at the M stage: SR/Cause/EPC/PRId, exception and interrupt request, mfc0/mtc0.
// Optional `CP0_EPC_BYPASS_EN forwards a same-cycle mtc0 EPC write onto EPCOut.
module cp0_unit #(
  parameter logic [31:0] PRID_VALUE = 32'h2023_0007
) (
  input logic       clk,
  input logic       reset,
  cp0_unit_if.slave bus
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic        req;
  logic [31:0] victim_pc;

  assign int_req   = (|(bus.HWInt & im_q)) & ie_q & ~exl_q;
  assign exc_req   = (bus.ExcCodeIn != 5'd0) & ~exl_q;
  assign req       = ~reset & (int_req | exc_req);
  assign victim_pc = bus.VPC & 32'hFFFF_FFFC;
  assign bus.Req   = req;

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    ip_d       = bus.HWInt;
    if (req) begin
      // An exception drops any same-cycle mtc0 write.
      exl_d      = 1'b1;
      bd_d       = bus.BDIn;
      exc_code_d = int_req ? 5'd0 : bus.ExcCodeIn;
      epc_d      = bus.BDIn ? victim_pc - 32'd4 : victim_pc;
    end else if (bus.en) begin
      case (bus.CP0Add)
        ADDR_SR: begin
          im_d  = bus.CP0In[15:10];
          exl_d = bus.CP0In[1];
          ie_d  = bus.CP0In[0];
        end
        ADDR_EPC: epc_d = bus.CP0In;
        default: ;
      endcase
    end
    if (bus.EXLClr) exl_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  always_comb begin
    case (bus.CP0Add)
      ADDR_SR:    bus.CP0Out = {16'b0, im_q, 8'b0, exl_q, ie_q};
      ADDR_CAUSE: bus.CP0Out = {bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b0};
      ADDR_EPC:   bus.CP0Out = epc_q;
      ADDR_PRID:  bus.CP0Out = PRID_VALUE;
      default:    bus.CP0Out = 32'd0;
    endcase
  end

`ifdef CP0_EPC_BYPASS_EN
  assign bus.EPCOut = (bus.en && bus.CP0Add == ADDR_EPC && !req) ? bus.CP0In : epc_q;
`else
  assign bus.EPCOut = epc_q;
`endif

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: directed scenarios then random traffic against a register model.
module tb_cp0_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cp0_unit_if bus ();

  cp0_unit dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic        rst;
    logic        en;
    logic [4:0]  add;
    logic [31:0] cin;
    logic [31:0] vpc;
    logic        bd;
    logic [4:0]  ec;
    logic [5:0]  hw;
    logic        exlclr;
  } stim_t;

  typedef struct {
    logic        req;
    logic [31:0] rd;
    logic [31:0] epc_out;
    int          cyc;
  } exp_t;

  exp_t  exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  stim_t cur;

  // Architectural register images, as the programmer sees them.
  logic [31:0] m_sr, m_cause, m_epc;

  function automatic stim_t mk(logic rst, logic en, logic [4:0] add, logic [31:0] cin,
                               logic [31:0] vpc, logic bd, logic [4:0] ec, logic [5:0] hw,
                               logic exlclr);
    stim_t s;
    s.rst = rst; s.en = en; s.add = add; s.cin = cin; s.vpc = vpc;
    s.bd = bd; s.ec = ec; s.hw = hw; s.exlclr = exlclr;
    return s;
  endfunction

  function automatic logic m_int(stim_t s);
    return ((s.hw & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req(stim_t s);
    if (s.rst) return 1'b0;
    return m_int(s) || (s.ec != 5'd0 && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(logic [4:0] a);
    if (a == 5'd12) return m_sr;
    if (a == 5'd13) return m_cause;
    if (a == 5'd14) return m_epc;
    if (a == 5'd15) return 32'h2023_0007;
    return 32'd0;
  endfunction

  task automatic model_update();
    logic [31:0] sr, cause, epc, base;
    logic        take, irq;
    if (cur.rst) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
      return;
    end
    take  = m_req(cur);
    irq   = m_int(cur);
    sr    = m_sr;
    cause = m_cause;
    epc   = m_epc;
    cause[15:10] = cur.hw;
    if (take) begin
      sr[1]      = 1'b1;
      cause[31]  = cur.bd;
      cause[6:2] = irq ? 5'd0 : cur.ec;
      base       = {cur.vpc[31:2], 2'b00};
      epc        = cur.bd ? base - 32'd4 : base;
    end else if (cur.en) begin
      if (cur.add == 5'd12) sr = cur.cin & 32'h0000_FC03;
      if (cur.add == 5'd14) epc = cur.cin;
    end
    if (cur.exlclr) sr[1] = 1'b0;
    m_sr = sr; m_cause = cause; m_epc = epc;
  endtask

  task automatic apply(stim_t s);
    reset         = s.rst;
    bus.en        = s.en;
    bus.CP0Add    = s.add;
    bus.CP0In     = s.cin;
    bus.VPC       = s.vpc;
    bus.BDIn      = s.bd;
    bus.ExcCodeIn = s.ec;
    bus.HWInt     = s.hw;
    bus.EXLClr    = s.exlclr;
    cur           = s;
  endtask

  task automatic step(stim_t s);
    exp_t e;
    @(posedge clk);
    model_update();
    #1;
    apply(s);
    cyc++;
    e.req = m_req(s);
    e.rd  = m_read(s.add);
`ifdef CP0_EPC_BYPASS_EN
    e.epc_out = (s.en && s.add == 5'd14 && !e.req) ? s.cin : m_epc;
`else
    e.epc_out = m_epc;
`endif
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] req_v, int c);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, c, act, req_v);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("req", {31'd0, bus.Req}, {31'd0, e.req}, e.cyc);
        check("cp0out", bus.CP0Out, e.rd, e.cyc);
        check("epcout", bus.EPCOut, e.epc_out, e.cyc);
      end
    end
  end

  function automatic stim_t rand_stim();
    stim_t s;
    logic [4:0] addrs [5];
    addrs[0] = 5'd12; addrs[1] = 5'd13; addrs[2] = 5'd14; addrs[3] = 5'd15;
    addrs[4] = 5'($urandom);
    s.rst    = ($urandom_range(99, 0) < 2);
    s.en     = ($urandom_range(99, 0) < 30);
    s.add    = addrs[$urandom_range(4, 0)];
    s.cin    = $urandom;
    s.vpc    = $urandom;
    s.bd     = 1'($urandom);
    s.ec     = ($urandom_range(99, 0) < 60) ? 5'd0 : 5'($urandom);
    s.hw     = 6'($urandom);
    s.exlclr = ($urandom_range(99, 0) < 15);
    return s;
  endfunction

  initial begin : driver
    m_sr = 0; m_cause = 0; m_epc = 0;
    apply(mk(1, 0, 5'd15, 0, 0, 0, 5'd4, 0, 0));
    // Reset with a pending exception code; Req must stay low.
    step(mk(1, 0, 5'd15, 0, 0, 0, 5'd4, 0, 0));
    step(mk(0, 0, 5'd12, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 5'd13, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 5'd14, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 5'd15, 0, 0, 0, 0, 0, 0));
    // Interrupt on IM[10].
    step(mk(0, 1, 5'd12, 32'h0000_0401, 0, 0, 0, 0, 0));
    step(mk(0, 0, 5'd12, 0, 32'h3010, 0, 0, 6'b000001, 0));
    step(mk(0, 0, 5'd14, 0, 0, 0, 0, 6'b000001, 0));
    step(mk(0, 0, 5'd13, 0, 0, 0, 0, 6'b000001, 0));
    step(mk(0, 0, 5'd12, 0, 0, 0, 0, 0, 1));
    // Exception in a delay slot.
    step(mk(0, 0, 5'd12, 0, 32'h3008, 1, 5'd4, 0, 0));
    step(mk(0, 0, 5'd14, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 5'd13, 0, 0, 0, 0, 0, 1));
    step(mk(0, 0, 5'd12, 0, 0, 0, 0, 0, 0));
    // Interrupt beats a simultaneous exception.
    step(mk(0, 0, 5'd13, 0, 32'h4000, 0, 5'd10, 6'b000001, 0));
    step(mk(0, 0, 5'd13, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 5'd14, 0, 0, 0, 0, 0, 1));
    // mtc0 EPC dropped under Req, then taken without Req.
    step(mk(0, 1, 5'd14, 32'h3100, 32'h5000, 0, 5'd5, 0, 0));
    step(mk(0, 0, 5'd14, 0, 0, 0, 0, 0, 1));
    step(mk(0, 1, 5'd14, 32'h3100, 0, 0, 0, 0, 0));
    step(mk(0, 0, 5'd14, 0, 0, 0, 0, 0, 0));
    // EXL masks a new exception; IP keeps following HWInt.
    step(mk(0, 0, 5'd13, 0, 32'h6000, 0, 5'd5, 0, 0));
    step(mk(0, 0, 5'd13, 0, 32'h7000, 0, 5'd12, 6'b101010, 0));
    step(mk(0, 0, 5'd13, 0, 32'h7000, 0, 5'd12, 6'b010101, 0));
    step(mk(0, 0, 5'd14, 0, 0, 0, 0, 0, 0));
    // mtc0 SR with EXL=1 alongside EXLClr; then VPC=0 delay-slot wrap.
    step(mk(0, 1, 5'd12, 32'h0000_FC03, 0, 0, 0, 0, 1));
    step(mk(0, 0, 5'd12, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 5'd14, 0, 32'h0000_0000, 1, 5'd1, 0, 0));
    step(mk(0, 0, 5'd14, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 3000; i++) step(rand_stim());
    @(posedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
